prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider_pkg.sv | 11 +
 rtl/prog_clock_divider_chan.sv | 94 +++++++++
 rtl/prog_clock_divider.sv | 46 ++++
 tb/tb_prog_clock_divider.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared constants for the programmable clock divider.
//   CNT_W_DEF   : default counter / ratio width
//   DEF_DIV_DEF : default divide ratio loaded at reset
//   MIN_DIV     : smallest legal ratio; captured 0 and 1 are raised to this
package prog_clock_divider_pkg;

   localparam int CNT_W_DEF   = 8;
   localparam int DEF_DIV_DEF = 125;
   localparam int MIN_DIV     = 2;

endpackage

// File: rtl/prog_clock_divider_chan.sv
// Single divider channel.
// The counter runs 0..D-1. clk_o is low for (D+1)/2 cycles, then high for
// D/2 cycles. tick_o marks the last high cycle. A new ratio sits in a shadow
// register and is only applied when the counter restarts, so a period is
// never cut short or stretched.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i           : run enable; low holds the counter at 0
//   sync_i         : restart strobe, shared with the other channels
//   div_i, load_i  : requested ratio and its capture strobe
//   clk_o          : divided clock (registered)
//   tick_o         : one-cycle pulse per output period (registered)
//   busy_o         : a captured ratio is waiting to be applied
module clk_div_chan
   import prog_clock_divider_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = DEF_DIV_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic             load_i,
   output logic             clk_o,
   output logic             tick_o,
   output logic             busy_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] act_q;
   logic [CNT_W-1:0] shd_q;
   logic             pend_q;
   logic             clk_q;
   logic             tick_q;

   logic [CNT_W-1:0] cap_div;
   logic [CNT_W-1:0] new_act;
   logic [CNT_W:0]   half;
   logic             wrap;
   logic             restart;
   logic             apply;
   logic             clk_nxt;

   always_comb begin
      cap_div = (div_i < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_i;
      wrap    = (cnt_q == act_q - CNT_W'(1));
      // Disable and sync both restart the count, so either is a safe
      // point to switch ratio, as is the natural wrap.
      restart = !en_i || sync_i;
      apply   = restart || wrap;
      // A load coincident with an apply point skips the shadow.
      new_act = load_i ? cap_div : (pend_q ? shd_q : act_q);
      // One extra bit so (D+1) cannot overflow for D = 2^CNT_W-1.
      half    = ({1'b0, act_q} + (CNT_W+1)'(1)) >> 1;
      clk_nxt = ({1'b0, cnt_q} >= half);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         act_q  <= CNT_W'(DEF_DIV);
         shd_q  <= CNT_W'(DEF_DIV);
         pend_q <= 1'b0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         if (apply) begin
            act_q  <= new_act;
            pend_q <= 1'b0;
            if (load_i) shd_q <= cap_div;
         end else if (load_i) begin
            shd_q  <= cap_div;
            pend_q <= 1'b1;
         end

         if (restart) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= wrap ? '0 : cnt_q + CNT_W'(1);
            clk_q  <= clk_nxt;
            tick_q <= wrap;
         end
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;
   assign busy_o = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel is an independent
// clk_div_chan; only sync_i is shared.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i           : per-channel run enable
//   sync_i         : common restart strobe
//   div_i          : per-channel ratio, channel n at [n*CNT_W +: CNT_W]
//   load_i         : per-channel ratio capture strobe
//   clk_o, tick_o  : per-channel divided clock and period pulse
//   busy_o         : per-channel ratio-pending flag
module prog_clock_divider
   import prog_clock_divider_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = DEF_DIV_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [NUM_CH-1:0]       en_i,
   input  logic                    sync_i,
   input  logic [NUM_CH*CNT_W-1:0] div_i,
   input  logic [NUM_CH-1:0]       load_i,
   output logic [NUM_CH-1:0]       clk_o,
   output logic [NUM_CH-1:0]       tick_o,
   output logic [NUM_CH-1:0]       busy_o
);

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      clk_div_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .en_i    (en_i[n]),
         .sync_i  (sync_i),
         .div_i   (div_i[n*CNT_W +: CNT_W]),
         .load_i  (load_i[n]),
         .clk_o   (clk_o[n]),
         .tick_o  (tick_o[n]),
         .busy_o  (busy_o[n])
      );
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int GUARD  = 1000;

   logic                    clk_i = 1'b0;
   logic                    rst_n_i;
   logic [NUM_CH-1:0]       en_i;
   logic                    sync_i;
   logic [NUM_CH*CNT_W-1:0] div_i;
   logic [NUM_CH-1:0]       load_i;
   logic [NUM_CH-1:0]       clk_o;
   logic [NUM_CH-1:0]       tick_o;
   logic [NUM_CH-1:0]       busy_o;

   int errors = 0;
   int checks = 0;

   prog_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(125)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (en_i),
      .sync_i  (sync_i),
      .div_i   (div_i),
      .load_i  (load_i),
      .clk_o   (clk_o),
      .tick_o  (tick_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic do_load(input int ch, input int val);
      div_i[ch*CNT_W +: CNT_W] = 8'(val);
      load_i[ch] = 1'b1;
      @(negedge clk_i);
      load_i[ch] = 1'b0;
   endtask

   task automatic wait_tick(input int ch);
      int g = 0;
      @(negedge clk_i);
      while (!tick_o[ch] && g < GUARD) begin
         @(negedge clk_i);
         g++;
      end
      if (g >= GUARD) check("wait_tick_timeout", 1, 0);
   endtask

   task automatic wait_busy_clear(input int ch);
      int g = 0;
      while (busy_o[ch] && g < GUARD) begin
         @(negedge clk_i);
         g++;
      end
      if (g >= GUARD) check("busy_timeout", 1, 0);
   endtask

   // Number of low samples from the next cycle until clk_o rises.
   task automatic low_run(input int ch, output int lo);
      int g = 0;
      lo = 0;
      @(negedge clk_i);
      while (!clk_o[ch] && g < GUARD) begin
         lo++;
         g++;
         @(negedge clk_i);
      end
   endtask

   // Syncs to the next rising clk_o, then measures one high phase and the
   // following low phase, plus tick count and tick on the last high cycle.
   task automatic measure(input int ch, output int hi, output int lo,
                          output int tk, output int tl);
      int  g = 0;
      logic prev;
      hi = 0; lo = 0; tk = 0; tl = 0;
      @(negedge clk_i);
      prev = clk_o[ch];
      @(negedge clk_i);
      while (!(prev == 1'b0 && clk_o[ch] == 1'b1) && g < GUARD) begin
         prev = clk_o[ch];
         @(negedge clk_i);
         g++;
      end
      while (clk_o[ch] && g < GUARD) begin
         hi++;
         tl = int'(tick_o[ch]);
         tk += int'(tick_o[ch]);
         @(negedge clk_i);
         g++;
      end
      while (!clk_o[ch] && g < GUARD) begin
         lo++;
         tk += int'(tick_o[ch]);
         @(negedge clk_i);
         g++;
      end
   endtask

   task automatic check_period(input string tag, input int ch, input int exp_hi, input int exp_lo);
      int hi, lo, tk, tl;
      measure(ch, hi, lo, tk, tl);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_ticks"}, tk, 1);
      check({tag, "_tick_last_hi"}, tl, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lo;
      int n;
      int mism;

      rst_n_i = 1'b0;
      en_i    = '0;
      sync_i  = 1'b0;
      div_i   = '0;
      load_i  = '0;

      repeat (3) @(negedge clk_i);
      check("rst_clk_o", clk_o, 0);
      check("rst_tick_o", tick_o, 0);
      check("rst_busy_o", busy_o, 0);

      // Default ratio from reset
      en_i    = 2'b11;
      rst_n_i = 1'b1;
      low_run(0, lo);
      check("first_low_ch0", lo, 63);
      check_period("def_ch0", 0, 62, 63);
      check_period("def_ch1", 1, 62, 63);

      // Load 4 on ch0 at C=10; the tick sample has C=0
      wait_tick(0);
      repeat (10) @(negedge clk_i);
      do_load(0, 4);
      check("load4_busy", busy_o[0], 1);
      n = 0;
      for (int g = 0; g < GUARD && !tick_o[0]; g++) begin
         if (busy_o[0]) n++;
         @(negedge clk_i);
      end
      check("load4_busy_cycles", n, 114);
      check("load4_busy_clear", busy_o[0], 0);
      low_run(0, lo);
      check("load4_first_low", lo, 2);
      check_period("div4", 0, 2, 2);

      // Load 3 on ch0 exactly on the wrap cycle (C=3 of a ratio-4 period)
      wait_tick(0);
      repeat (3) @(negedge clk_i);
      do_load(0, 3);
      check("wrapload_tick", tick_o[0], 1);
      check("wrapload_busy", busy_o[0], 0);
      low_run(0, lo);
      check("wrapload_first_low", lo, 2);
      check("wrapload_busy_later", busy_o[0], 0);
      check_period("div3", 0, 1, 2);

      // Clamp of 0 and 1 on ch1
      do_load(1, 0);
      check("load0_busy", busy_o[1], 1);
      wait_busy_clear(1);
      check_period("div0", 1, 1, 1);
      do_load(1, 5);
      wait_busy_clear(1);
      check_period("div5", 1, 2, 3);
      do_load(1, 1);
      wait_busy_clear(1);
      check_period("div1", 1, 1, 1);

      // Both channels back to 125, then offset them and sync
      div_i  = {8'd125, 8'd125};
      load_i = 2'b11;
      @(negedge clk_i);
      load_i = 2'b00;
      wait_busy_clear(0);
      wait_busy_clear(1);
      en_i = 2'b00;
      @(negedge clk_i);
      check("dis_clk_o", clk_o, 0);
      check("dis_tick_o", tick_o, 0);
      repeat (2) @(negedge clk_i);
      en_i = 2'b10;
      repeat (50) @(negedge clk_i);
      en_i = 2'b11;
      repeat (40) @(negedge clk_i);
      check("presync_clk_o", clk_o, 2'b10);
      sync_i = 1'b1;
      @(negedge clk_i);
      sync_i = 1'b0;
      check("sync_clk_o", clk_o, 0);
      check("sync_tick_o", tick_o, 0);
      mism = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (clk_o[0] !== clk_o[1] || tick_o[0] !== tick_o[1]) mism++;
      end
      check("sync_aligned_mismatches", mism, 0);
      check_period("post_sync_ch0", 0, 62, 63);

      // Pending 7 on ch0 applied by disable
      do_load(0, 7);
      check("p7_busy", busy_o[0], 1);
      en_i = 2'b10;
      @(negedge clk_i);
      check("p7_dis_busy", busy_o[0], 0);
      check("p7_dis_clk", clk_o[0], 0);
      check("p7_dis_tick", tick_o[0], 0);
      repeat (3) @(negedge clk_i);
      en_i = 2'b11;
      low_run(0, lo);
      check("p7_first_low", lo, 4);
      check_period("div7", 0, 3, 4);

      // Reset mid-period with a pending ratio on ch1
      do_load(1, 9);
      check("p9_busy", busy_o[1], 1);
      rst_n_i = 1'b0;
      #1;
      check("async_rst_clk_o", clk_o, 0);
      check("async_rst_tick_o", tick_o, 0);
      check("async_rst_busy_o", busy_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      low_run(1, lo);
      check("rerst_first_low_ch1", lo, 63);
      check_period("rerst_ch1", 1, 62, 63);
      check_period("rerst_ch0", 0, 62, 63);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
